// File: rtl/hdp_sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM model: byte-masked writes on port 0,
// registered reads on both ports with 1- or 2-cycle latency and collision reporting.
module hdp_sram_1rw1r_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  localparam int NUM_WMASKS  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("hdp_sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("hdp_sram_1rw1r_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd0;
  logic                  rd1;
  logic                  wr0;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd1_word;

  always_comb begin
    rd0      = rst_n & ~csb0 & web0;
    wr0      = rst_n & ~csb0 & ~web0 & (|wmask0);
    rd1      = rst_n & ~csb1;
    hit      = rd1 & wr0 & (addr1 == addr0);
    rd1_word = mem[addr1];
    if (hit && BYPASS != 0) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) rd1_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr0) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= din0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 1 snapshots the array at the accepting edge so that a write on the
  // same or a later edge can never leak into an earlier read.
  logic                  s1_v0;
  logic                  s1_v1;
  logic                  s1_col;
  logic [DATA_WIDTH-1:0] s1_d0;
  logic [DATA_WIDTH-1:0] s1_d1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v0  <= 1'b0;
      s1_v1  <= 1'b0;
      s1_col <= 1'b0;
      s1_d0  <= '0;
      s1_d1  <= '0;
    end else begin
      s1_v0  <= rd0;
      s1_v1  <= rd1;
      s1_col <= hit;
      if (rd0) s1_d0 <= mem[addr0];
      if (rd1) s1_d1 <= rd1_word;
    end
  end

  // READ_LATENCY output stages; data registers only load on a valid beat so
  // the final stage holds its last read value between strobes.
  logic                  pv0  [READ_LATENCY];
  logic                  pv1  [READ_LATENCY];
  logic                  pcol [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd0  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd1  [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        pv0[s]  <= 1'b0;
        pv1[s]  <= 1'b0;
        pcol[s] <= 1'b0;
        pd0[s]  <= '0;
        pd1[s]  <= '0;
      end
    end else begin
      pv0[0]  <= s1_v0;
      pv1[0]  <= s1_v1;
      pcol[0] <= s1_col;
      if (s1_v0) pd0[0] <= s1_d0;
      if (s1_v1) pd1[0] <= s1_d1;
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        pv0[s]  <= pv0[s-1];
        pv1[s]  <= pv1[s-1];
        pcol[s] <= pcol[s-1];
        if (pv0[s-1]) pd0[s] <= pd0[s-1];
        if (pv1[s-1]) pd1[s] <= pd1[s-1];
      end
    end
  end

  assign dout0       = pd0[READ_LATENCY-1];
  assign dout0_valid = pv0[READ_LATENCY-1];
  assign dout1       = pd1[READ_LATENCY-1];
  assign dout1_valid = pv1[READ_LATENCY-1];
  assign collision   = pcol[READ_LATENCY-1];

endmodule

// File: tb/tb_hdp_sram_1rw1r_param.sv
// Scoreboard bench: three configurations of the SRAM share one stimulus stream;
// a word-array reference model predicts each read and a monitor checks outputs.
module tb_hdp_sram_1rw1r_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [7:0]  wmask0;
  logic [10:0] addr0, addr1;
  logic [63:0] din0;

  always #5 clk = ~clk;

  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic [63:0] c_d0, c_d1;
  logic [2:0]  v0, v1, co;
  logic [2:0][63:0] d0, d1;

  // A: 32x2048 latency 1 bypass; B: 32x2048 latency 2 no bypass; C: 64x16 latency 2 bypass
  hdp_sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .BYTE_WIDTH(8), .READ_LATENCY(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0[3:0]), .addr0(addr0),
    .din0(din0[31:0]), .dout0(a_d0), .dout0_valid(v0[0]), .csb1(csb1), .addr1(addr1),
    .dout1(a_d1), .dout1_valid(v1[0]), .collision(co[0]));
  hdp_sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .BYTE_WIDTH(8), .READ_LATENCY(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0[3:0]), .addr0(addr0),
    .din0(din0[31:0]), .dout0(b_d0), .dout0_valid(v0[1]), .csb1(csb1), .addr1(addr1),
    .dout1(b_d1), .dout1_valid(v1[1]), .collision(co[1]));
  hdp_sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0[3:0]),
    .din0(din0), .dout0(c_d0), .dout0_valid(v0[2]), .csb1(csb1), .addr1(addr1[3:0]),
    .dout1(c_d1), .dout1_valid(v1[2]), .collision(co[2]));

  assign d0[0] = {32'h0, a_d0};
  assign d1[0] = {32'h0, a_d1};
  assign d0[1] = {32'h0, b_d0};
  assign d1[1] = {32'h0, b_d1};
  assign d0[2] = c_d0;
  assign d1[2] = c_d1;

  int dw  [3] = '{32, 32, 64};
  int aw  [3] = '{11, 11, 4};
  int lat [3] = '{1, 2, 2};
  int byp [3] = '{1, 0, 1};

  typedef struct {
    logic [63:0] data;
    logic        col;
    int          due;
  } exp_t;

  logic [63:0] mem [3][2048];
  exp_t        sq [6][$];
  logic [63:0] last [6];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", what, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lanes(input logic [63:0] base, input logic [63:0] din,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = base;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  // Drive one request cycle and let the model predict its consequences.
  task automatic step(input logic c0, input logic we, input logic [7:0] wm, input logic [10:0] a0,
                      input logic [63:0] d, input logic c1, input logic [10:0] a1);
    int   x0, x1;
    logic [7:0]  m;
    logic [63:0] dd, v;
    logic        wr, hit;
    exp_t e;
    @(negedge clk);
    csb0 = c0; web0 = we; wmask0 = wm; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        x0  = int'(a0) % (1 << aw[k]);
        x1  = int'(a1) % (1 << aw[k]);
        m   = (dw[k] == 64) ? wm : {4'h0, wm[3:0]};
        dd  = (dw[k] == 64) ? d : {32'h0, d[31:0]};
        wr  = !c0 && !we && (m != 8'h0);
        hit = wr && !c1 && (x0 == x1);
        if (!c0 && we) begin
          e.data = mem[k][x0]; e.col = 1'b0; e.due = cyc + 1 + lat[k];
          sq[2*k].push_back(e);
        end
        if (!c1) begin
          v = mem[k][x1];
          if (hit && byp[k] != 0) v = lanes(v, dd, m);
          e.data = v; e.col = hit; e.due = cyc + 1 + lat[k];
          sq[2*k+1].push_back(e);
        end
        if (wr) mem[k][x0] = lanes(mem[k][x0], dd, m);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1, 8'h0, 11'h0, 64'h0, 1'b1, 11'h0);
  endtask

  // Reset with random (ignored) requests on the bus; in-flight reads are discarded.
  task automatic reset_cycles(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    for (int q = 0; q < 6; q++) begin
      sq[q].delete();
      last[q] = 64'h0;
    end
    repeat (n) begin
      csb0 = 1'($urandom); web0 = 1'($urandom); wmask0 = 8'($urandom);
      addr0 = 11'($urandom); din0 = {$urandom, $urandom}; csb1 = 1'($urandom); addr1 = 11'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    csb0 = 1'b1; csb1 = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          int          q;
          logic        v, c;
          logic [63:0] act;
          exp_t        e;
          q   = 2*k + p;
          v   = p ? v1[k] : v0[k];
          c   = p ? co[k] : 1'b0;
          act = p ? d1[k] : d0[k];
          if (v === 1'b1) begin
            if (sq[q].size() == 0) begin
              chk($sformatf("dut%0d port%0d unexpected valid", k, p), 64'd1, 64'd0);
            end else begin
              e = sq[q].pop_front();
              chk($sformatf("dut%0d port%0d latency", k, p), 64'(cyc), 64'(e.due));
              chk($sformatf("dut%0d port%0d data", k, p), act, e.data);
              if (p == 1) chk($sformatf("dut%0d collision", k), 64'(c), 64'(e.col));
              last[q] = e.data;
            end
          end else begin
            chk($sformatf("dut%0d port%0d valid", k, p), 64'(v), 64'd0);
            chk($sformatf("dut%0d port%0d hold", k, p), act, last[q]);
            if (p == 1) chk($sformatf("dut%0d collision idle", k), 64'(co[k]), 64'd0);
            if (sq[q].size() != 0 && sq[q][0].due <= cyc) begin
              chk($sformatf("dut%0d port%0d missing valid", k, p), 64'd0, 64'd1);
              void'(sq[q].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r, a, b;
    logic [31:0] w;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 2048; i++) mem[k][i] = 64'h0;
    for (int q = 0; q < 6; q++) last[q] = 64'h0;
    rst_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 8'h0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset dout0", k), d0[k], 64'h0);
      chk($sformatf("dut%0d reset dout1", k), d1[k], 64'h0);
      chk($sformatf("dut%0d reset valids", k), 64'({v0[k], v1[k], co[k]}), 64'h0);
    end
    rst_n = 1'b1;

    // directed: full write then read back on port 0
    step(1'b0, 1'b0, 8'hFF, 11'h010, {2{32'hDEADBEEF}}, 1'b1, 11'h0);
    step(1'b0, 1'b1, 8'h00, 11'h010, 64'h0, 1'b1, 11'h0);
    idle(3);

    // fill 0..31 and 2016..2047 with addr*0x01010101
    for (int i = 0; i < 64; i++) begin
      a = (i < 32) ? i : 2016 + i - 32;
      w = 32'(a) * 32'h01010101;
      step(1'b0, 1'b0, 8'hFF, 11'(a), {w, w}, 1'b1, 11'h0);
    end

    // partial-lane write
    step(1'b0, 1'b0, 8'hFF, 11'h01E, {2{32'h11223344}}, 1'b1, 11'h0);
    step(1'b0, 1'b0, 8'h05, 11'h01E, {2{32'hAABBCCDD}}, 1'b1, 11'h0);
    step(1'b1, 1'b1, 8'h00, 11'h0, 64'h0, 1'b0, 11'h01E);

    // same-edge collision, then different address, then zero-mask write
    step(1'b0, 1'b0, 8'hFF, 11'h014, {2{32'h12345678}}, 1'b1, 11'h0);
    step(1'b0, 1'b0, 8'hFF, 11'h014, {2{32'hCAFEF00D}}, 1'b0, 11'h014);
    step(1'b0, 1'b0, 8'hFF, 11'h014, {2{32'h0BADF00D}}, 1'b0, 11'h015);
    step(1'b0, 1'b0, 8'h00, 11'h015, {2{32'h55555555}}, 1'b0, 11'h015);
    idle(3);

    // continuous reads on both ports 0..15
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 11'(i), 64'h0, 1'b0, 11'(i));

    // 64-bit lane selection and top-address wrap
    step(1'b0, 1'b0, 8'hFF, 11'd15, 64'h0123456789ABCDEF, 1'b1, 11'h0);
    step(1'b0, 1'b0, 8'h81, 11'd15, 64'hFFEEDDCCBBAA9988, 1'b1, 11'h0);
    step(1'b0, 1'b1, 8'h00, 11'd15, 64'h0, 1'b0, 11'd0);
    idle(3);

    // read in flight when reset hits, then retention check
    step(1'b0, 1'b1, 8'h00, 11'h010, 64'h0, 1'b0, 11'h01E);
    reset_cycles(2);
    step(1'b0, 1'b1, 8'h00, 11'h010, 64'h0, 1'b0, 11'h01E);
    idle(3);

    // randomized traffic with occasional mid-flight resets
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 63);
      a = (r < 32) ? r : 2016 + r - 32;
      r = $urandom_range(0, 63);
      b = (r < 32) ? r : 2016 + r - 32;
      if ($urandom_range(0, 9) < 3) b = a;
      step(1'($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom),
           11'(a), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 11'(b));
      if (it % 150 == 149) reset_cycles($urandom_range(1, 3));
    end
    idle(6);

    for (int q = 0; q < 6; q++) chk($sformatf("queue%0d drained", q), 64'(sq[q].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdp_sram_1rw1r_param.md
# hdp_sram_1rw1r_param

Parametrised, synthesisable single-clock 1RW+1R SRAM model with byte-granular write masks, configurable read latency (1 or 2 cycles), per-port read-valid strobes, and defined read/write collision behaviour. Successor to the fixed 32x2048 OpenRAM macro model. Sits between the core's load/store and fetch units and the on-chip memory map, so the same RTL serves simulation, FPGA prototyping and macro-replacement studies at any width and depth.

## Interface

- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 11, address bits; depth = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, request-to-data cycles; legal values 1 or 2 (elaboration error otherwise)
- BYPASS, 1, 1 = port 1 returns write-forwarded data on same-cycle same-address collision; 0 = returns old data

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- csb0  input  1  port 0 chip select, active-low
- web0  input  1  port 0 write enable, active-low (0 = write, 1 = read)
- wmask0  input  NUM_WMASKS  per-lane write enable, bit i covers din0[i*BYTE_WIDTH +: BYTE_WIDTH]
- addr0  input  ADDR_WIDTH  port 0 address
- din0  input  DATA_WIDTH  port 0 write data
- dout0  output  DATA_WIDTH  port 0 read data
- dout0_valid  output  1  one-cycle strobe, dout0 carries new read data
- csb1  input  1  port 1 chip select, active-low (read only)
- addr1  input  ADDR_WIDTH  port 1 address
- dout1  output  DATA_WIDTH  port 1 read data
- dout1_valid  output  1  one-cycle strobe, dout1 carries new read data
- collision  output  1  one-cycle strobe aligned with dout1_valid: that read hit a same-cycle port 0 write to the same address

## Operation

- Request accepted on rising edge when csbN=0 and rst_n=1. Port 0: web0=0 write, web0=1 read.
- Write: lanes with wmask0[i]=1 updated at the accepting edge; other lanes unchanged. wmask0=0 with web0=0: no array change, no read, no valid.
- Array read occurs at the accepting edge (stage 1); READ_LATENCY=2 adds one output register stage. Data reflects array contents before that edge's write, except port 1 under BYPASS=1.
- Port 0 write cycle produces no dout0 update; dout0 and dout0_valid behave as idle.
- Collision (port 1 read, port 0 write, addr1==addr0, same edge, wmask0 nonzero): BYPASS=1 -> dout1 = masked lanes from din0, remaining lanes old word; BYPASS=0 -> old word. collision=1 in both cases, aligned with dout1_valid. Zero wmask0 is not a collision.
- dout0/dout1 hold last value when no new read completes; valid strobes low.
- Memory array not reset; power-up contents X in simulation.
- Reset (rst_n=0 at an edge): dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision=0; all pipeline valid bits cleared, so in-flight reads are discarded and produce no strobe after reset release. Requests presented while rst_n=0 ignored (no write, no read).
- Back-to-back reads on both ports fully pipelined: one result per port per cycle.

## Timing

- Read accepted at edge k -> dout/valid (and collision) updated at edge k+READ_LATENCY, valid high exactly one cycle.
- Write at edge k visible to any read accepted at edge k+1 or later on either port.
- READ_LATENCY=2: write at edge k+1 does not affect a read accepted at edge k.
- Outputs driven only from registers; no combinational input-to-output path.
- First request accepted on the first edge with rst_n=1.

## Test plan

- Reset then write addr 0x010 din 0xDEADBEEF wmask 0xF, read port 0 addr 0x010 -> dout0=0xDEADBEEF with dout0_valid at edge +READ_LATENCY, for both latencies.
- Write 0x11223344 full, then write 0xAABBCCDD wmask 0x5 same addr, read port 1 -> 0x11BB33DD.
- Same-edge port 0 write 0xCAFEF00D wmask 0xF and port 1 read same addr holding 0x12345678: BYPASS=1 -> dout1=0xCAFEF00D, BYPASS=0 -> 0x12345678; collision=1 with dout1_valid both cases; different address -> collision=0.
- Continuous reads both ports, addresses 0..15 ascending after fill with addr*0x01010101 -> one valid per cycle per port, data in order, no gaps.
- READ_LATENCY=2, read issued, rst_n low at next edge -> outputs 0, no valid strobe after release; memory contents retained on subsequent read.
- Parameter sweep DATA_WIDTH=64/BYTE_WIDTH=8, ADDR_WIDTH=4: write wmask 0x81 to addr 15 -> only bytes 7 and 0 change; addr 15 wraps correctly, no aliasing to addr 0.
